// File: rtl/shift_left_4bit_reg.sv
`default_nettype none
// ============================================================================
//  Module      : shift_left_4bit_reg
//  Description : Registered logical left shifter behind a one-entry
//                valid/ready output buffer. Optional rotate mode is enabled
//                by defining SHL_ROTATE_EN, which adds the rot input.
//  Revision    : 1.0  initial release
// ============================================================================
module shift_left_4bit_reg #(
    parameter int WIDTH = 4,
    parameter int NW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in,
    input  logic [NW-1:0]    n,
`ifdef SHL_ROTATE_EN
    input  logic             rot,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] shout,
    output logic             zero
);

    logic               w_accept;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_lo;
    logic [WIDTH-1:0]   w_hi;
    logic [WIDTH-1:0]   w_res;
    logic [WIDTH-1:0]   w_sh;

    logic               r_valid;
    logic [WIDTH-1:0]   r_out;
    logic [WIDTH-1:0]   r_shout;
    logic               r_zero;

    assign in_ready = !r_valid || out_ready;
    assign w_accept = in_valid && in_ready;

    // The high half of the double-width product is exactly the shifted-out bits.
    assign w_prod = {{WIDTH{1'b0}}, in} << n;
    assign w_lo   = w_prod[WIDTH-1:0];
    assign w_hi   = w_prod[2*WIDTH-1:WIDTH];

`ifdef SHL_ROTATE_EN
    // Rotation folds the shifted-out bits back into the vacated low end.
    assign w_res = rot ? (w_lo | w_hi) : w_lo;
    assign w_sh  = rot ? {WIDTH{1'b0}} : w_hi;
`else
    assign w_res = w_lo;
    assign w_sh  = w_hi;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_out   <= {WIDTH{1'b0}};
            r_shout <= {WIDTH{1'b0}};
            r_zero  <= 1'b1;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_out   <= w_res;
            r_shout <= w_sh;
            r_zero  <= (w_res == {WIDTH{1'b0}});
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign out_valid = r_valid;
    assign out       = r_out;
    assign shout     = r_shout;
    assign zero      = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_shift_left_4bit_reg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_shift_left_4bit_reg
//  Description : Self-checking bench for shift_left_4bit_reg, directed
//                scenarios plus randomized traffic against an arithmetic model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_shift_left_4bit_reg;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in;
    logic [1:0]   n;
    logic         rot;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out;
    logic [W-1:0] shout;
    logic         zero;

    int total;
    int bad;

    shift_left_4bit_reg #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in        (in),
        .n         (n),
`ifdef SHL_ROTATE_EN
        .rot       (rot),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .shout     (shout),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: shifting left by k is multiplication by 2**k; the low W bits
    // are the result and the quotient by 2**W is what fell off the top.
    function automatic int prod_of(input int a, input int k);
        return a * (2 ** k);
    endfunction

    function automatic logic [W-1:0] exp_out(input int a, input int k, input logic r);
        int p;
        p = prod_of(a, k);
        if (r) return W'((p % (2 ** W)) + (p / (2 ** W)));
        return W'(p % (2 ** W));
    endfunction

    function automatic logic [W-1:0] exp_shout(input int a, input int k, input logic r);
        if (r) return '0;
        return W'(prod_of(a, k) / (2 ** W));
    endfunction

    task automatic do_reset;
        @(negedge clk);
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        rot = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        rot = 1'b0;
        in = 'x;
        n = 'x;
        repeat (2) @(negedge clk);
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready_during: got %b want 1", in_ready); end
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (out !== 4'b0000) begin bad++; $display("FAIL reset_out: got %b want 0000", out); end
        total++; if (shout !== 4'b0000) begin bad++; $display("FAIL reset_shout: got %b want 0000", shout); end
        total++; if (zero !== 1'b1) begin bad++; $display("FAIL reset_zero: got %b want 1", zero); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_shift_sequence;
        logic [1:0]   ns [3]  = '{2'd1, 2'd3, 2'd2};
        logic [W-1:0] eo [3]  = '{4'b1000, 4'b0000, 4'b0000};
        logic [W-1:0] es [3]  = '{4'b0001, 4'b0110, 4'b0011};
        logic         ez [3]  = '{1'b0, 1'b1, 1'b1};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in = 4'b1100;
            n = ns[i];
            @(negedge clk);
            in_valid = 1'b0;
            in = 'x;
            n = 'x;
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL seq%0d_valid: got %b want 1", i, out_valid); end
            total++; if (out !== eo[i]) begin bad++; $display("FAIL seq%0d_out: got %b want %b", i, out, eo[i]); end
            total++; if (shout !== es[i]) begin bad++; $display("FAIL seq%0d_shout: got %b want %b", i, shout, es[i]); end
            total++; if (zero !== ez[i]) begin bad++; $display("FAIL seq%0d_zero: got %b want %b", i, zero, ez[i]); end
        end
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL seq_drain_valid: got %b want 0", out_valid); end
        total++; if (out !== 4'b0000 || shout !== 4'b0011) begin bad++; $display("FAIL seq_drain_hold: got %b/%b want 0000/0011", out, shout); end
    endtask

    task automatic test_back_to_back;
        logic [W-1:0] eo [4] = '{4'b0011, 4'b0110, 4'b1100, 4'b1000};
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i <= 4; i++) begin
            @(negedge clk);
            if (i > 0) begin
                total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL b2b%0d_valid: got %b want 1", i - 1, out_valid); end
                total++; if (out !== eo[i-1]) begin bad++; $display("FAIL b2b%0d_out: got %b want %b", i - 1, out, eo[i-1]); end
            end
            if (i < 4) begin
                in_valid = 1'b1;
                in = 4'b0011;
                n = 2'(i);
            end else begin
                in_valid = 1'b0;
            end
        end
    endtask

    task automatic test_backpressure;
        do_reset();
        @(negedge clk);
        in_valid = 1'b1;
        in = 4'b0101;
        n = 2'd1;
        out_ready = 1'b0;
        @(negedge clk);
        in = 4'b1111;
        n = 2'd0;
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
        total++; if (out !== 4'b1010) begin bad++; $display("FAIL bp_out: got %b want 1010", out); end
        @(negedge clk);
        total++; if (out !== 4'b1010 || out_valid !== 1'b1) begin bad++; $display("FAIL bp_hold: got %b v=%b want 1010 v=1", out, out_valid); end
        out_ready = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
        @(negedge clk);
        in_valid = 1'b0;
        total++; if (out !== 4'b1111 || out_valid !== 1'b1) begin bad++; $display("FAIL bp_new_out: got %b v=%b want 1111 v=1", out, out_valid); end
        total++; if (shout !== 4'b0000 || zero !== 1'b0) begin bad++; $display("FAIL bp_new_flags: got shout=%b zero=%b want 0000/0", shout, zero); end
    endtask

    task automatic test_async_reset;
        do_reset();
        @(negedge clk);
        in_valid = 1'b1;
        in = 4'b0111;
        n = 2'd1;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1 || out !== 4'b1110) begin bad++; $display("FAIL ar_setup: got %b v=%b want 1110 v=1", out, out_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ar_valid: got %b want 0", out_valid); end
        total++; if (out !== 4'b0000 || zero !== 1'b1) begin bad++; $display("FAIL ar_out: got %b zero=%b want 0000/1", out, zero); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL ar_in_ready: got %b want 1", in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ar_after_valid: got %b want 0", out_valid); end
    endtask

`ifdef SHL_ROTATE_EN
    task automatic test_rotate;
        do_reset();
        @(negedge clk);
        in_valid = 1'b1; in = 4'b1100; n = 2'd1; rot = 1'b1;
        @(negedge clk);
        total++; if (out !== 4'b1001 || shout !== 4'b0000) begin bad++; $display("FAIL rot1: got %b/%b want 1001/0000", out, shout); end
        n = 2'd3;
        @(negedge clk);
        total++; if (out !== 4'b0110 || zero !== 1'b0) begin bad++; $display("FAIL rot3: got %b z=%b want 0110 z=0", out, zero); end
        rot = 1'b0; n = 2'd1;
        @(negedge clk);
        in_valid = 1'b0;
        total++; if (out !== 4'b1000 || shout !== 4'b0001) begin bad++; $display("FAIL rot_off: got %b/%b want 1000/0001", out, shout); end
    endtask
`endif

    task automatic test_random;
        logic         m_valid;
        logic [W-1:0] m_out;
        logic [W-1:0] m_shout;
        logic         m_zero;
        logic         iv, ordy, rr, acc;
        int           a, k;
        do_reset();
        m_valid = 1'b0; m_out = '0; m_shout = '0; m_zero = 1'b1;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            total++; if (out_valid !== m_valid) begin bad++; $display("FAIL rnd%0d_valid: got %b want %b", c, out_valid, m_valid); end
            total++; if (out !== m_out) begin bad++; $display("FAIL rnd%0d_out: got %b want %b", c, out, m_out); end
            total++; if (shout !== m_shout || zero !== m_zero) begin bad++; $display("FAIL rnd%0d_flags: got %b/%b want %b/%b", c, shout, zero, m_shout, m_zero); end
            iv   = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 3) != 0);
            a    = int'($urandom_range(0, 15));
            k    = int'($urandom_range(0, 3));
`ifdef SHL_ROTATE_EN
            rr   = 1'($urandom_range(0, 1));
`else
            rr   = 1'b0;
`endif
            in_valid  = iv;
            out_ready = ordy;
            rot       = rr;
            if (iv) begin in = W'(a); n = 2'(k); end
            else    begin in = 'x;    n = 'x;    end
            #1;
            total++; if (in_ready !== (!m_valid || ordy)) begin bad++; $display("FAIL rnd%0d_in_ready: got %b want %b", c, in_ready, !m_valid || ordy); end
            acc = iv && (!m_valid || ordy);
            @(posedge clk);
            if (acc) begin
                m_valid = 1'b1;
                m_out   = exp_out(a, k, rr);
                m_shout = exp_shout(a, k, rr);
                m_zero  = (m_out == '0);
            end else if (ordy) begin
                m_valid = 1'b0;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        rot = 1'b0;
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset();
        test_shift_sequence();
        test_back_to_back();
        test_backpressure();
        test_async_reset();
`ifdef SHL_ROTATE_EN
        test_rotate();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/shift_left_4bit_reg.md
Name:
shift_left_4bit_reg

Overview:
Registered logical left shifter with a valid/ready stream interface on input and output. Accepts a WIDTH-bit operand and a shift amount, and produces the truncated shifted result one cycle later. Also produces the bits shifted out and a zero flag. Used as a pipelined shift stage in the datapath; default configuration is 4 bits with a 2-bit shift amount.

Parameters:
WIDTH, 4, operand/result width in bits (>=2, power of two)
NW, $clog2(WIDTH) (=2), shift-amount width; amount range 0..WIDTH-1

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous reset, active-low
in_valid  input  1  operand/amount valid
in_ready  output  1  stage can accept this cycle
in  input  WIDTH  operand
n  input  NW  left-shift amount, unsigned
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
out  output  WIDTH  (in << n) truncated to WIDTH
shout  output  WIDTH  bits shifted out of the top, right-justified, zero-extended
zero  output  1  1 when out == 0

Behaviour:
- One clock (clk); asynchronous active-low reset rst_n. All outputs are registered except in_ready.
- Reset (async assert, sync release): out=0, shout=0, zero=1, out_valid=0. in_ready=1 during and after reset.
- in_ready = !out_valid || out_ready (combinational; one-entry output buffer with pass-through on drain).
- Accept: when in_valid && in_ready at a rising edge, capture the result.
  - out <= low WIDTH bits of in<<n.
  - shout <= bits [2*WIDTH-1:WIDTH] of the 2*WIDTH-bit product {WIDTH'b0,in}<<n.
  - zero <= (result==0).
  - out_valid <= 1.
- Latency: 1 cycle from accept to out_valid. Throughput: 1 per cycle when out_ready is held high.
- Drain: out_valid && out_ready with no accept -> out_valid <= 0. out, shout and zero hold their last values.
- Simultaneous drain and accept -> new result loaded and out_valid stays 1. No bubble.
- Stall: out_valid && !out_ready -> in_ready=0. out, shout, zero and out_valid are held stable.
- n=0 -> out=in, shout=0. Logical shift only: vacated LSBs are filled with 0.
- Asserting reset mid-transfer discards the pending result immediately. No partial state survives.
- in and n are ignored when not accepted. X on these inputs without in_valid must not propagate.

Optional Feature:
Macro SHL_ROTATE_EN.
- Defined: adds input port rot (1 bit), sampled with in. rot=1 selects rotate-left: out <= in rotated left by n, shout <= 0, zero <= (in==0). rot=0 behaves exactly as the base shifter.
- Not defined: port rot does not exist and the block is a pure logical shifter. Timing, reset and handshake are identical in both builds.

Test Plan:
- Reset: hold rst_n=0, then release -> out=0000, shout=0000, zero=1, out_valid=0, in_ready=1.
- Shift sequence with out_ready=1, in=1100:
  - n=01 -> next cycle out=1000, shout=0001, zero=0.
  - n=11 -> out=0000, shout=0110, zero=1.
  - n=10 -> out=0000, shout=0011, zero=1.
  - Each result appears with out_valid=1 one cycle after accept.
- Back-to-back throughput: in=0011 with n=0,1,2,3 on consecutive cycles, out_ready=1 -> outputs 0011, 0110, 1100, 1000 on consecutive cycles; out_valid stays high with no gaps.
- Backpressure: out_ready=0 after accepting in=0101,n=01 -> out=1010 held, in_ready=0, and a new in=1111 is not accepted. Raise out_ready -> 1010 drains and 1111 is accepted the same edge.
- Async reset mid-stall: with out_valid=1 and out_ready=0, pulse rst_n low between clock edges -> out_valid=0 and out=0000 immediately, without waiting for a clock edge.
- SHL_ROTATE_EN build, rot=1:
  - in=1100, n=01 -> out=1001, shout=0000.
  - in=1100, n=11 -> out=0110.
  - rot=0 results match the base build.
